// File: rtl/skinny_round_ctrl.sv
// skinny_round_ctrl: round controller for the SKINNY-128-384+ core (Romulus-N).
// Drives the state-register enable/select/init lines, generates the 6-bit
// round-constant LFSR and counts rounds; start/done handshake with the mode
// controller.
// Optional feature: define SKINNY_CTRL_BLKCNT_EN to add the blk_cnt output
// (saturating count of completed blocks).
//
// Handshake: start is sampled only in IDLE; done is a single-cycle pulse one
// cycle after the final round; start seen while busy or in DONE is dropped,
// never queued. abort cancels from any state and wins over every other input.
module skinny_round_ctrl #(
   parameter int ROUNDS = 40,
   parameter int CW     = 6
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic          init,
   input  logic          stall,
   input  logic          abort,
   output logic          st_enc,
   output logic          st_se,
   output logic          st_init,
   output logic [5:0]    rc,
   output logic [CW-1:0] round,
   output logic          busy,
   output logic          done,
   output logic [1:0]    fsm_state
`ifdef SKINNY_CTRL_BLKCNT_EN
   ,
   output logic [15:0]   blk_cnt
`endif
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_LOAD  = 2'd1,
      S_ROUND = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t        state_q;
   state_t        state_d;
   logic [5:0]    rc_q;
   logic [CW-1:0] round_q;
   logic          init_q;
   logic          last_round;

   assign last_round = (round_q == CW'(ROUNDS - 1));

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state and output decode; outputs come from registered state, with
   // stall and abort only allowed to gate the enable.
   always_comb begin
      state_d = state_q;
      st_enc  = 1'b0;
      st_se   = 1'b0;
      st_init = 1'b0;
      busy    = 1'b0;
      done    = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) state_d = S_LOAD;
         end
         S_LOAD: begin
            st_enc  = 1'b1;
            st_se   = 1'b1;
            st_init = init_q;
            busy    = 1'b1;
            state_d = S_ROUND;
         end
         S_ROUND: begin
            st_enc = ~stall;
            busy   = 1'b1;
            if (!stall && last_round) state_d = S_DONE;
         end
         S_DONE: begin
            done    = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
      if (abort) begin
         state_d = S_IDLE;
         st_enc  = 1'b0;
      end
   end

   // Round-constant LFSR, round counter and captured init select.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rc_q    <= 6'h00;
         round_q <= '0;
         init_q  <= 1'b0;
      end else if (abort) begin
         rc_q    <= 6'h00;
         round_q <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start) init_q <= init;
            end
            S_LOAD: begin
               rc_q    <= 6'h01;
               round_q <= '0;
            end
            S_ROUND: begin
               // The exit edge leaves rc/round on the final round's values.
               if (!stall && !last_round) begin
                  rc_q    <= {rc_q[4:0], rc_q[5] ^ rc_q[4] ^ 1'b1};
                  round_q <= round_q + CW'(1);
               end
            end
            default: ;
         endcase
      end
   end

`ifdef SKINNY_CTRL_BLKCNT_EN
   logic [15:0] blk_cnt_q;

   // Completed-block counter; saturates, cleared only by reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         blk_cnt_q <= 16'h0000;
      end else if (state_q == S_DONE && blk_cnt_q != 16'hFFFF) begin
         blk_cnt_q <= blk_cnt_q + 16'd1;
      end
   end

   assign blk_cnt = blk_cnt_q;
`endif

   assign rc        = rc_q;
   assign round     = round_q;
   assign fsm_state = state_q;

endmodule

// File: tb/tb_skinny_round_ctrl.sv
// Directed bench for skinny_round_ctrl (ROUNDS=40): full blocks with init=1/0,
// mid-round stall, abort, back-to-back starts and asynchronous reset mid-block.
module tb_skinny_round_ctrl;

   localparam int ROUNDS = 40;
   localparam int CW     = 6;

   // SKINNY 6-bit round constants for rounds 0..39, worked out by hand.
   localparam logic [5:0] RC_TBL [40] = '{
      6'h01, 6'h03, 6'h07, 6'h0F, 6'h1F, 6'h3E, 6'h3D, 6'h3B, 6'h37, 6'h2F,
      6'h1E, 6'h3C, 6'h39, 6'h33, 6'h27, 6'h0E, 6'h1D, 6'h3A, 6'h35, 6'h2B,
      6'h16, 6'h2C, 6'h18, 6'h30, 6'h21, 6'h02, 6'h05, 6'h0B, 6'h17, 6'h2E,
      6'h1C, 6'h38, 6'h31, 6'h23, 6'h06, 6'h0D, 6'h1B, 6'h36, 6'h2D, 6'h1A
   };

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          start = 1'b0;
   logic          init = 1'b0;
   logic          stall = 1'b0;
   logic          abort = 1'b0;
   logic          st_enc, st_se, st_init, busy, done;
   logic [5:0]    rc;
   logic [CW-1:0] round;
   logic [1:0]    fsm_state;
`ifdef SKINNY_CTRL_BLKCNT_EN
   logic [15:0]   blk_cnt;
`endif

   int n_vec = 0;
   int n_err = 0;
   int exp_blk = 0;
   logic [5:0] exp_q [$];

   skinny_round_ctrl #(.ROUNDS(ROUNDS), .CW(CW)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .init      (init),
      .stall     (stall),
      .abort     (abort),
      .st_enc    (st_enc),
      .st_se     (st_se),
      .st_init   (st_init),
      .rc        (rc),
      .round     (round),
      .busy      (busy),
      .done      (done),
      .fsm_state (fsm_state)
`ifdef SKINNY_CTRL_BLKCNT_EN
      ,
      .blk_cnt   (blk_cnt)
`endif
   );

   // Clock.
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, want %0h", tag, act, exp);
      end
   endtask

   task automatic check_quiet(input string tag);
      check({tag, "_enc"},   st_enc,  0);
      check({tag, "_se"},    st_se,   0);
      check({tag, "_init"},  st_init, 0);
      check({tag, "_busy"},  busy,    0);
      check({tag, "_done"},  done,    0);
   endtask

   task automatic check_blk(input string tag);
`ifdef SKINNY_CTRL_BLKCNT_EN
      check(tag, blk_cnt, exp_blk);
`else
      n_vec = n_vec + 0;
`endif
   endtask

   // One block: optional stall of stall_n cycles at round stall_r, optional
   // abort at round abort_r (-1 disables), optional stall held during LOAD.
   task automatic run_block(input logic init_v, input int stall_r, input int stall_n,
                            input int abort_r, input logic load_stall);
      exp_q.delete();
      for (int i = 0; i < ROUNDS; i++) exp_q.push_back(RC_TBL[i]);
      @(negedge clk);
      start = 1'b1;
      init  = init_v;
      #1;
      check("pre_busy", busy, 0);
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      init  = ~init_v;
      stall = load_stall;
      #1;
      check("load_enc",  st_enc,  1);
      check("load_se",   st_se,   1);
      check("load_init", st_init, init_v);
      check("load_busy", busy,    1);
      check("load_done", done,    0);
      @(posedge clk);
      for (int r = 0; r < ROUNDS; r++) begin
         @(negedge clk);
         stall = 1'b0;
         if (r == abort_r) begin
            abort = 1'b1;
            #1;
            check("abort_enc", st_enc, 0);
            @(posedge clk);
            @(negedge clk);
            abort = 1'b0;
            #1;
            check_quiet("abort");
            check("abort_rc",    rc,    0);
            check("abort_round", round, 0);
            for (int k = 0; k < 3; k++) begin
               @(negedge clk);
               #1;
               check("abort_nodone", done, 0);
            end
            return;
         end
         if (r == stall_r) begin
            for (int s = 0; s < stall_n; s++) begin
               stall = 1'b1;
               #1;
               check("stall_enc",   st_enc, 0);
               check("stall_rc",    rc,     RC_TBL[r]);
               check("stall_round", round,  r);
               check("stall_busy",  busy,   1);
               @(posedge clk);
               @(negedge clk);
            end
            stall = 1'b0;
         end
         #1;
         check("rnd_enc",   st_enc,  1);
         check("rnd_se",    st_se,   0);
         check("rnd_init",  st_init, 0);
         check("rnd_busy",  busy,    1);
         check("rnd_done",  done,    0);
         check("rnd_rc",    rc,      exp_q.pop_front());
         check("rnd_round", round,   r);
         @(posedge clk);
      end
      @(negedge clk);
      #1;
      check("done_pulse", done,   1);
      check("done_busy",  busy,   0);
      check("done_enc",   st_enc, 0);
      exp_blk++;
      @(negedge clk);
      #1;
      check_quiet("post");
      check_blk("blk_after");
   endtask

   task automatic back_to_back();
      int load_cnt = 0;
      int done_cnt = 0;
      int first_done = -1;
      int second_done = -1;
      int last_load = -1;
      @(negedge clk);
      start = 1'b1;
      init  = 1'b1;
      for (int j = 1; j <= 90; j++) begin
         @(negedge clk);
         #1;
         if (done) begin
            done_cnt++;
            if (first_done < 0) first_done = j;
            else second_done = j;
         end
         if (st_se) begin
            load_cnt++;
            last_load = j;
         end
         if (j == 43) check_quiet("b2b_gap");
      end
      check("b2b_done_cnt",   done_cnt,    2);
      check("b2b_first_done", first_done,  42);
      check("b2b_second",     second_done, 85);
      check("b2b_load_cnt",   load_cnt,    3);
      check("b2b_last_load",  last_load,   87);
      exp_blk += 2;
      @(negedge clk);
      start = 1'b0;
      abort = 1'b1;
      #1;
      check("b2b_abort_enc", st_enc, 0);
      @(negedge clk);
      abort = 1'b0;
      #1;
      check_quiet("b2b_abort");
      check("b2b_abort_rc", rc, 0);
      check_blk("blk_b2b");
   endtask

   task automatic reset_mid_block();
      @(negedge clk);
      start = 1'b1;
      init  = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (15) @(negedge clk);
      #2;
      rst = 1'b0;
      exp_blk = 0;
      #1;
      check_quiet("rst_mid");
      check("rst_mid_rc",    rc,    0);
      check("rst_mid_round", round, 0);
      check_blk("rst_mid_blk");
      @(negedge clk);
      rst = 1'b1;
      #1;
      check_quiet("rst_rel");
      @(negedge clk);
      #1;
      check_quiet("rst_rel2");
      check("rst_rel2_rc", rc, 0);
   endtask

   initial begin
      rst = 1'b0;
      #1;
      check_quiet("reset");
      check("reset_rc",    rc,    0);
      check("reset_round", round, 0);
      check_blk("reset_blk");
      repeat (2) @(negedge clk);
      rst = 1'b1;
      #1;
      check_quiet("rel");
      @(negedge clk);
      stall = 1'b1;
      #1;
      check_quiet("idle_stall");
      stall = 1'b0;

      run_block(1'b1, -1, 0, -1, 1'b0);
      run_block(1'b0, -1, 0, -1, 1'b1);
      run_block(1'b1, 11, 3, -1, 1'b0);
      run_block(1'b1, -1, 0, 20, 1'b0);
      check_blk("blk_three");
      run_block(1'b0, -1, 0, -1, 1'b0);
      back_to_back();
      reset_mid_block();
      run_block(1'b1, -1, 0, -1, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
